bilinear_scale_ctrl: RTL and testbench

Frame-level sequencer for the bilinear interpolation calculator in the video-processing path. Per output pixel it walks the destination raster and emits the source-neighbour coordinates (x0, x1, y0, y1) plus fractional offsets to the pixel-fetch stage. It enforces a credit limit, because the 10-cycle calculator pipeline has no backpressure, and reports busy/done per frame.

---
 rtl/bilinear_scale_pkg.sv | 17 +
 rtl/bilinear_scale_ctrl_axis.sv | 67 ++++++
 rtl/bilinear_scale_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_bilinear_scale_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bilinear_scale_pkg.sv
// Shared types and widths for the bilinear scaler frame sequencer.
// Imported by the axis stepper and the top-level controller.
package bilinear_scale_pkg;

  localparam int CW       = 12;
  localparam int SCALE_FW = 8;
  localparam int ACC_W    = CW + SCALE_FW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bilinear_scale_ctrl_axis.sv
// One scaling axis: fixed-point accumulator with clear/step/saturate,
// split into clamped neighbour indices and a fractional weight.
module bilinear_axis_step #(
  parameter int CW = bilinear_scale_pkg::CW,
  parameter int FW = bilinear_scale_pkg::SCALE_FW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic [CW-1:0]    size,
  input  logic [CW+FW-1:0] inc,
  output logic [CW-1:0]    p0,
  output logic [CW-1:0]    p1,
  output logic [FW-1:0]    offset
);
  import bilinear_scale_pkg::*;

  localparam int AW = CW + FW;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_n;
  logic [AW:0]   sum;
  logic [CW-1:0] ip;
  logic [CW-1:0] lim;
  logic [CW-1:0] p0_n;
  logic [CW-1:0] p1_n;
  logic [FW-1:0] off_n;

  // Next accumulator value and its clamped neighbour split.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, inc};
    acc_n = acc;
    if (clr) begin
      acc_n = '0;
    end else if (step) begin
      acc_n = sum[AW] ? '1 : sum[AW-1:0];
    end
    ip  = acc_n[AW-1:FW];
    lim = size - CW'(1);
    if (ip >= lim) begin
      p0_n  = lim;
      p1_n  = lim;
      off_n = '0;
    end else begin
      p0_n  = ip;
      p1_n  = ip + CW'(1);
      off_n = acc_n[FW-1:0];
    end
  end

  // Accumulator and registered coordinate outputs move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      p0     <= '0;
      p1     <= '0;
      offset <= '0;
    end else if (clr || step) begin
      acc    <= acc_n;
      p0     <= p0_n;
      p1     <= p1_n;
      offset <= off_n;
    end
  end

endmodule

// File: rtl/bilinear_scale_ctrl.sv
// Frame sequencer: walks the destination raster, emits source
// neighbour coordinates under a credit limit, tracks pixels in flight.
module bilinear_scale_ctrl #(
  parameter int SCALE_FW = bilinear_scale_pkg::SCALE_FW,
  parameter int CW       = bilinear_scale_pkg::CW,
  parameter int CREDITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [CW-1:0]          i_src_width,
  input  logic [CW-1:0]          i_src_height,
  input  logic [CW-1:0]          i_dst_width,
  input  logic [CW-1:0]          i_dst_height,
  input  logic [CW+SCALE_FW-1:0] i_step_x,
  input  logic [CW+SCALE_FW-1:0] i_step_y,
  output logic                   o_coord_valid,
  input  logic                   i_coord_ready,
  output logic [CW-1:0]          o_src_x0,
  output logic [CW-1:0]          o_src_x1,
  output logic [CW-1:0]          o_src_y0,
  output logic [CW-1:0]          o_src_y1,
  output logic [SCALE_FW-1:0]    o_offset_x,
  output logic [SCALE_FW-1:0]    o_offset_y,
  output logic                   o_coord_eol,
  output logic                   o_coord_last,
  input  logic                   i_pix_valid,
  input  logic                   i_credit_ret,
  output logic                   o_busy,
  output logic                   o_done
);
  import bilinear_scale_pkg::*;

  localparam int AW  = CW + SCALE_FW;
  localparam int CRW = $clog2(CREDITS + 1);
  localparam int OW  = 2 * CW + 1;

  state_t state;

  logic [CW-1:0] src_w;
  logic [CW-1:0] src_h;
  logic [CW-1:0] dst_w;
  logic [CW-1:0] dst_h;
  logic [AW-1:0] step_x;
  logic [AW-1:0] step_y;

  logic [CRW-1:0] credit;
  logic [CRW-1:0] credit_nxt;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  out_nxt;

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [CW-1:0] col_n;
  logic [CW-1:0] row_n;
  logic          eol_n;
  logic          last_n;

  logic hs;
  logic load;
  logic clr_x;
  logic stp_x;
  logic stp_y;

  assign hs    = o_coord_valid & i_coord_ready;
  assign load  = (state == ST_LOAD);
  assign clr_x = load | (hs & o_coord_eol);
  assign stp_x = hs & ~o_coord_eol;
  assign stp_y = hs & o_coord_eol;

  bilinear_axis_step #(.CW(CW), .FW(SCALE_FW)) u_x (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_x),
    .step   (stp_x),
    .size   (src_w),
    .inc    (step_x),
    .p0     (o_src_x0),
    .p1     (o_src_x1),
    .offset (o_offset_x)
  );

  bilinear_axis_step #(.CW(CW), .FW(SCALE_FW)) u_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (load),
    .step   (stp_y),
    .size   (src_h),
    .inc    (step_y),
    .p0     (o_src_y0),
    .p1     (o_src_y1),
    .offset (o_offset_y)
  );

  // Next credit and in-flight counts; a spare credit return is dropped.
  always_comb begin
    credit_nxt = credit;
    if (hs && !i_credit_ret) begin
      credit_nxt = credit - CRW'(1);
    end else if (!hs && i_credit_ret && credit != CRW'(CREDITS)) begin
      credit_nxt = credit + CRW'(1);
    end
    out_nxt = outstanding;
    if (hs && !i_pix_valid) begin
      out_nxt = outstanding + OW'(1);
    end else if (!hs && i_pix_valid && outstanding != '0) begin
      out_nxt = outstanding - OW'(1);
    end
  end

  // Raster position of the beat to be presented next.
  always_comb begin
    col_n = col;
    row_n = row;
    if (load) begin
      col_n = '0;
      row_n = '0;
    end else if (hs) begin
      if (o_coord_eol) begin
        col_n = '0;
        row_n = row + CW'(1);
      end else begin
        col_n = col + CW'(1);
      end
    end
    eol_n  = (col_n == dst_w - CW'(1));
    last_n = eol_n && (row_n == dst_h - CW'(1));
  end

  // Credit and in-flight counters persist across frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit      <= CRW'(CREDITS);
      outstanding <= '0;
    end else begin
      credit      <= credit_nxt;
      outstanding <= out_nxt;
    end
  end

  // Column/row counters and the registered eol/last flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      o_coord_eol  <= 1'b0;
      o_coord_last <= 1'b0;
    end else if (load || hs) begin
      col          <= col_n;
      row          <= row_n;
      o_coord_eol  <= eol_n;
      o_coord_last <= last_n;
    end
  end

  // Frame FSM with registered valid/busy/done and config latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      o_coord_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      src_w         <= '0;
      src_h         <= '0;
      dst_w         <= '0;
      dst_h         <= '0;
      step_x        <= '0;
      step_y        <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            src_w  <= i_src_width;
            src_h  <= i_src_height;
            dst_w  <= i_dst_width;
            dst_h  <= i_dst_height;
            step_x <= i_step_x;
            step_y <= i_step_y;
            o_busy <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (dst_w == '0 || dst_h == '0) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= ST_DONE;
          end else begin
            o_coord_valid <= (credit_nxt != '0);
            state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (hs && o_coord_last) begin
            o_coord_valid <= 1'b0;
            state         <= ST_DRAIN;
          end else if (!o_coord_valid || hs) begin
            o_coord_valid <= (credit_nxt != '0);
          end
        end
        ST_DRAIN: begin
          if (out_nxt == '0) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bilinear_scale_ctrl.sv
// Directed bench for bilinear_scale_ctrl with CREDITS=4.
// Downstream credit/pixel returns are modelled as owed counters.
module tb_bilinear_scale_ctrl;

  localparam int CW = 12;
  localparam int FW = 8;
  localparam int CR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic [CW-1:0] i_src_width = '0;
  logic [CW-1:0] i_src_height = '0;
  logic [CW-1:0] i_dst_width = '0;
  logic [CW-1:0] i_dst_height = '0;
  logic [CW+FW-1:0] i_step_x = '0;
  logic [CW+FW-1:0] i_step_y = '0;
  logic o_coord_valid;
  logic i_coord_ready = 1'b0;
  logic [CW-1:0] o_src_x0, o_src_x1, o_src_y0, o_src_y1;
  logic [FW-1:0] o_offset_x, o_offset_y;
  logic o_coord_eol, o_coord_last;
  logic i_pix_valid = 1'b0;
  logic i_credit_ret = 1'b0;
  logic o_busy, o_done;

  always #5 clk = ~clk;

  bilinear_scale_ctrl #(.SCALE_FW(FW), .CW(CW), .CREDITS(CR)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_src_width(i_src_width), .i_src_height(i_src_height),
    .i_dst_width(i_dst_width), .i_dst_height(i_dst_height),
    .i_step_x(i_step_x), .i_step_y(i_step_y),
    .o_coord_valid(o_coord_valid), .i_coord_ready(i_coord_ready),
    .o_src_x0(o_src_x0), .o_src_x1(o_src_x1),
    .o_src_y0(o_src_y0), .o_src_y1(o_src_y1),
    .o_offset_x(o_offset_x), .o_offset_y(o_offset_y),
    .o_coord_eol(o_coord_eol), .o_coord_last(o_coord_last),
    .i_pix_valid(i_pix_valid), .i_credit_ret(i_credit_ret),
    .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct packed {
    logic [CW-1:0] x0, x1, y0, y1;
    logic [FW-1:0] ox, oy;
    logic eol, last;
  } beat_t;

  beat_t blog[$];
  int total = 0;
  int bad = 0;
  int owed_c = 0;
  int owed_p = 0;
  int done_cnt = 0;
  bit cred_en = 0;
  bit pix_en = 0;
  bit prev_stall = 0;
  logic [79:0] held = '0;

  int x0t[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int x1t[8] = '{1, 1, 2, 2, 3, 3, 3, 3};
  int oxt[8] = '{0, 128, 0, 128, 0, 128, 0, 0};

  function automatic logic [79:0] bundle();
    return {13'd0, o_coord_valid, o_src_x0, o_src_x1, o_src_y0,
            o_src_y1, o_offset_x, o_offset_y, o_coord_eol,
            o_coord_last};
  endfunction

  function automatic logic [31:0] axm(int a, int size);
    int ip, fr, lim;
    ip  = a / 256;
    fr  = a % 256;
    lim = size - 1;
    if (ip >= lim) return {12'(lim), 12'(lim), 8'(0)};
    return {12'(ip), 12'(ip + 1), 8'(fr)};
  endfunction

  task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic hs;
    hs = o_coord_valid && i_coord_ready;
    if (prev_stall) chk("stall_hold", bundle(), held);
    prev_stall = o_coord_valid && !i_coord_ready;
    held = bundle();
    if (hs) begin
      blog.push_back(beat_t'({o_src_x0, o_src_x1, o_src_y0, o_src_y1,
                              o_offset_x, o_offset_y, o_coord_eol,
                              o_coord_last}));
      owed_c++;
      owed_p++;
    end
    if (o_done) done_cnt++;
    i_credit_ret = 1'b0;
    if (cred_en && owed_c > 0) begin
      i_credit_ret = 1'b1;
      owed_c--;
    end
    i_pix_valid = 1'b0;
    if (pix_en && owed_p > 0) begin
      i_pix_valid = 1'b1;
      owed_p--;
    end
    @(negedge clk);
  endtask

  task automatic start_frame(int sw, int sh, int dw, int dh,
                             int sx, int sy);
    i_src_width  = 12'(sw);
    i_src_height = 12'(sh);
    i_dst_width  = 12'(dw);
    i_dst_height = 12'(dh);
    i_step_x     = 20'(sx);
    i_step_y     = 20'(sy);
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
  endtask

  task automatic run_to_done(int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
  endtask

  initial begin
    logic [31:0] xm, ym;
    beat_t b;

    @(negedge clk);
    repeat (3) tick();
    chk("reset_outs", bundle(), 80'd0);
    chk("reset_busy", 80'({o_busy, o_done}), 80'd0);
    rst_n = 1'b1;
    tick();

    cred_en = 1;
    pix_en = 1;
    i_coord_ready = 1'b1;
    start_frame(4, 4, 8, 8, 'h80, 'h80);
    chk("busy_load", 80'(o_busy), 80'd1);
    run_to_done(300);
    chk("up_beats", 80'(blog.size()), 80'd64);
    chk("up_done", 80'(done_cnt), 80'd1);
    chk("up_busy_end", 80'(o_busy), 80'd0);
    for (int k = 0; k < 8; k++) begin
      b = blog[k];
      chk($sformatf("up_row0_%0d", k), 80'({b.x0, b.x1, b.ox}),
          80'({12'(x0t[k]), 12'(x1t[k]), 8'(oxt[k])}));
    end
    chk("up_eol6", 80'(blog[6].eol), 80'd0);
    chk("up_eol7", 80'(blog[7].eol), 80'd1);
    chk("up_last55", 80'({blog[55].eol, blog[55].last}), 80'b10);
    chk("up_last63", 80'({blog[63].eol, blog[63].last}), 80'b11);
    chk("up_row1_y", 80'({blog[8].y0, blog[8].y1, blog[8].oy}),
        80'({12'd0, 12'd1, 8'd128}));
    chk("up_row5_y", 80'({blog[40].y0, blog[40].y1, blog[40].oy}),
        80'({12'd2, 12'd3, 8'd128}));
    chk("up_row7_y", 80'({blog[56].y0, blog[56].y1, blog[56].oy}),
        80'({12'd3, 12'd3, 8'd0}));
    repeat (6) tick();
    chk("up_done_once", 80'(done_cnt), 80'd1);

    blog.delete();
    done_cnt = 0;
    cred_en = 0;
    pix_en = 0;
    start_frame(4, 4, 4, 4, 'h100, 'h100);
    repeat (20) tick();
    chk("cr_beats4", 80'(blog.size()), 80'd4);
    chk("cr_valid_low", 80'(o_coord_valid), 80'd0);
    cred_en = 1;
    tick();
    cred_en = 0;
    repeat (10) tick();
    chk("cr_beats5", 80'(blog.size()), 80'd5);
    chk("cr_pos", 80'({o_busy, o_src_x0, o_src_y0}),
        80'({1'b1, 12'd1, 12'd1}));

    #2 rst_n = 1'b0;
    #1 chk("rst_async", 80'({o_busy, o_coord_valid, o_src_x0, o_src_y0}),
           80'd0);
    @(negedge clk);
    chk("rst_nodone", 80'(o_done), 80'd0);
    rst_n = 1'b1;
    owed_c = 0;
    owed_p = 0;
    prev_stall = 0;
    done_cnt = 0;
    blog.delete();
    tick();

    start_frame(4, 4, 4, 4, 'h100, 'h100);
    repeat (20) tick();
    chk("rs_beats4", 80'(blog.size()), 80'd4);
    chk("rs_first", 80'({blog[0].x0, blog[0].y0}), 80'd0);
    chk("rs_b3", 80'({blog[3].x0, blog[3].eol}), 80'({12'd3, 1'b1}));
    i_start = 1'b1;
    i_dst_width = 12'd2;
    tick();
    i_start = 1'b0;
    cred_en = 1;
    pix_en = 1;
    run_to_done(200);
    chk("rs_beats16", 80'(blog.size()), 80'd16);
    chk("rs_done", 80'(done_cnt), 80'd1);
    chk("rs_eol1", 80'(blog[5].eol), 80'd0);
    chk("rs_last", 80'({blog[15].x0, blog[15].y0, blog[15].last}),
        80'({12'd3, 12'd3, 1'b1}));
    repeat (4) tick();

    blog.delete();
    done_cnt = 0;
    start_frame(4, 4, 5, 3, 'hCC, 'h155);
    for (int i = 0; i < 600 && done_cnt == 0; i++) begin
      i_coord_ready = 1'($urandom_range(0, 1));
      tick();
    end
    i_coord_ready = 1'b1;
    chk("rn_beats", 80'(blog.size()), 80'd15);
    chk("rn_done", 80'(done_cnt), 80'd1);
    for (int k = 0; k < 15; k++) begin
      b = blog[k];
      xm = axm((k % 5) * 'hCC, 4);
      ym = axm((k / 5) * 'h155, 4);
      chk($sformatf("rn_beat%0d", k),
          80'({b.x0, b.x1, b.y0, b.y1, b.ox, b.oy, b.eol, b.last}),
          80'({xm[31:20], xm[19:8], ym[31:20], ym[19:8], xm[7:0],
               ym[7:0], (k % 5) == 4, k == 14}));
    end
    repeat (4) tick();

    done_cnt = 0;
    start_frame(4, 4, 0, 4, 'h100, 'h100);
    chk("z_load", 80'({o_done, o_busy, o_coord_valid}), 80'b010);
    tick();
    chk("z_done", 80'({o_done, o_busy, o_coord_valid}), 80'b100);
    tick();
    chk("z_after", 80'({o_done, o_busy, o_coord_valid}), 80'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
